// File: rtl/seq_detect_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_stream_ctrl
//  Description : Session sequencer for a bit-serial Moore sequence detector.
//                Accepts parallel words over valid/ready, serializes them one
//                bit per clock onto the detector input, drives the detector
//                reset, counts detector hits and ends the session on word
//                exhaustion, hit limit or abort.
//  Ports       : clock/reset        - clock, asynchronous active-high reset
//                start/abort        - session start (IDLE only) / early end
//                word_count         - words in the session (latched at start)
//                hit_limit          - hits before early stop, 0 = unlimited
//                in_data/in_valid/in_ready - word source handshake
//                sequence_out       - serial bit to detector (registered)
//                det_reset          - detector reset (registered)
//                detector_in        - detector output
//                busy/done          - session in progress / end pulse
//                underrun           - sticky: source starved mid-session
//                hit_count          - saturating hit counter
//  Config      : SEQ_CTRL_LSB_FIRST_EN - when defined, words go out LSB
//                first; otherwise MSB first. Timing is identical.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_stream_ctrl #(
    parameter int WORD_W      = 8,
    parameter int CNT_W       = 16,
    parameter int DET_RST_CYC = 2,
    parameter int DRAIN_CYC   = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  word_count,
    input  logic [CNT_W-1:0]  hit_limit,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              sequence_out,
    output logic              det_reset,
    input  logic              detector_in,
    output logic              busy,
    output logic              done,
    output logic              underrun,
    output logic [CNT_W-1:0]  hit_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRST  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // One shared in-state cycle timer covers DRST, SHIFT and DRAIN.
    localparam int c_max_a   = (WORD_W > DET_RST_CYC) ? WORD_W : DET_RST_CYC;
    localparam int c_max_cyc = (c_max_a > DRAIN_CYC) ? c_max_a : DRAIN_CYC;
    localparam int c_tmr_w   = $clog2(c_max_cyc + 1);

    localparam logic [c_tmr_w-1:0] c_drst_last  = c_tmr_w'(DET_RST_CYC - 1);
    localparam logic [c_tmr_w-1:0] c_bit_last   = c_tmr_w'(WORD_W - 1);
    localparam logic [c_tmr_w-1:0] c_drain_last = c_tmr_w'(DRAIN_CYC - 1);

    state_t              r_state;
    state_t              w_next_state;
    logic [c_tmr_w-1:0]  r_tmr;
    logic [CNT_W-1:0]    r_words_left;
    logic [CNT_W-1:0]    r_hit_limit;
    logic [CNT_W-1:0]    r_hit_count;
    logic [WORD_W-1:0]   r_shreg;
    logic                r_seq_out;
    logic                r_det_reset;
    logic                r_det_reset_q;
    logic                r_underrun;

    logic                w_busy;
    logic                w_last_bit;
    logic                w_limit_hit;
    logic                w_stop;
    logic                w_ready;
    logic                w_take;
    logic                w_hit_en;
    logic                w_seq_next;
    logic                w_underrun_set;
    logic                w_first_bit;
    logic                w_sh_bit;
    logic [WORD_W-1:0]   w_in_rest;
    logic [WORD_W-1:0]   w_sh_rest;

    // r_shreg always holds the bits still to be sent, next bit at the
    // outgoing end; the first bit of a word goes straight to sequence_out.
`ifdef SEQ_CTRL_LSB_FIRST_EN
    assign w_first_bit = in_data[0];
    assign w_in_rest   = {1'b0, in_data[WORD_W-1:1]};
    assign w_sh_bit    = r_shreg[0];
    assign w_sh_rest   = {1'b0, r_shreg[WORD_W-1:1]};
`else
    assign w_first_bit = in_data[WORD_W-1];
    assign w_in_rest   = {in_data[WORD_W-2:0], 1'b0};
    assign w_sh_bit    = r_shreg[WORD_W-1];
    assign w_sh_rest   = {r_shreg[WORD_W-2:0], 1'b0};
`endif

    assign w_busy      = (r_state == ST_DRST) || (r_state == ST_LOAD) ||
                         (r_state == ST_SHIFT) || (r_state == ST_DRAIN);
    assign w_last_bit  = (r_state == ST_SHIFT) && (r_tmr == c_bit_last);
    assign w_limit_hit = (r_hit_limit != '0) && (r_hit_count >= r_hit_limit);
    // Ending conditions block in_ready so no word is consumed on the way out.
    assign w_stop      = abort || w_limit_hit;
    assign w_ready     = !w_stop &&
                         ((r_state == ST_LOAD) || (w_last_bit && (r_words_left != '0)));
    assign w_take      = in_valid && w_ready;
    // A hit is trusted only if the detector was out of reset last cycle.
    assign w_hit_en    = detector_in && !r_det_reset_q &&
                         ((r_state == ST_SHIFT) || (r_state == ST_LOAD) ||
                          (r_state == ST_DRAIN));

    always_comb begin
        w_next_state   = r_state;
        w_seq_next     = 1'b0;
        w_underrun_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (word_count == '0) ? ST_DONE : ST_DRST;
                end
            end
            ST_DRST: begin
                if (w_stop)                    w_next_state = ST_DONE;
                else if (r_tmr == c_drst_last) w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                if (w_stop) begin
                    w_next_state = ST_DONE;
                end else if (w_take) begin
                    w_next_state = ST_SHIFT;
                    w_seq_next   = w_first_bit;
                end
            end
            ST_SHIFT: begin
                if (w_stop) begin
                    w_next_state = ST_DONE;
                end else if (!w_last_bit) begin
                    w_seq_next = w_sh_bit;
                end else if (w_take) begin
                    w_seq_next = w_first_bit;
                end else if (r_words_left != '0) begin
                    w_next_state   = ST_LOAD;
                    w_underrun_set = 1'b1;
                end else begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_stop || (r_tmr == c_drain_last)) w_next_state = ST_DONE;
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tmr         <= '0;
            r_words_left  <= '0;
            r_hit_limit   <= '0;
            r_hit_count   <= '0;
            r_shreg       <= '0;
            r_seq_out     <= 1'b0;
            r_det_reset   <= 1'b1;
            r_det_reset_q <= 1'b1;
            r_underrun    <= 1'b0;
        end else begin
            // Timer restarts on every state change and on every new word.
            if ((w_next_state != r_state) || w_take) r_tmr <= '0;
            else                                     r_tmr <= r_tmr + c_tmr_w'(1);

            if (w_take)                    r_shreg <= w_in_rest;
            else if (r_state == ST_SHIFT)  r_shreg <= w_sh_rest;

            if ((r_state == ST_IDLE) && start) begin
                r_words_left <= word_count;
                r_hit_limit  <= hit_limit;
                r_hit_count  <= '0;
                r_underrun   <= 1'b0;
            end else begin
                if (w_take) r_words_left <= r_words_left - CNT_W'(1);
                if (w_hit_en && (r_hit_count != '1)) r_hit_count <= r_hit_count + CNT_W'(1);
                if (w_underrun_set) r_underrun <= 1'b1;
            end

            // Registered outputs track the state being entered.
            r_seq_out     <= w_seq_next;
            r_det_reset   <= !((w_next_state == ST_SHIFT) || (w_next_state == ST_DRAIN));
            r_det_reset_q <= r_det_reset;
        end
    end

    assign in_ready     = w_ready;
    assign sequence_out = r_seq_out;
    assign det_reset    = r_det_reset;
    assign busy         = w_busy;
    assign done         = (r_state == ST_DONE);
    assign underrun     = r_underrun;
    assign hit_count    = r_hit_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_stream_ctrl
//  Description : Self-checking bench for seq_detect_stream_ctrl paired with a
//                behavioural Moore detector for overlapping pattern 1011.
//                Expected results come from a session-level model built from
//                word lists, source gaps and plain cycle arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_stream_ctrl;

    localparam int WORD_W      = 8;
    localparam int CNT_W       = 16;
    localparam int DET_RST_CYC = 2;
    localparam int DRAIN_CYC   = 2;
    localparam int MAXW        = 8;
    localparam int MAXT        = 512;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [CNT_W-1:0]  word_count = '0;
    logic [CNT_W-1:0]  hit_limit = '0;
    logic [WORD_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              sequence_out;
    logic              det_reset;
    logic              detector_in;
    logic              busy;
    logic              done;
    logic              underrun;
    logic [CNT_W-1:0]  hit_count;

    logic [3:0]        r_hist = 4'b0;

    int                n_checks = 0;
    int                n_fail   = 0;

    logic [WORD_W-1:0] words [MAXW];
    int                gaps  [MAXW];
    logic              exp_dr [MAXT];
    logic              exp_sq [MAXT];
    int                exp_done_t;
    int                exp_hits;
    int                exp_consumed;
    logic              exp_und;

    always #5 clock = ~clock;

    seq_detect_stream_ctrl #(
        .WORD_W      (WORD_W),
        .CNT_W       (CNT_W),
        .DET_RST_CYC (DET_RST_CYC),
        .DRAIN_CYC   (DRAIN_CYC)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .word_count   (word_count),
        .hit_limit    (hit_limit),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .sequence_out (sequence_out),
        .det_reset    (det_reset),
        .detector_in  (detector_in),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun),
        .hit_count    (hit_count)
    );

    // Moore detector: output is a function of the last four received bits.
    always @(posedge clock) begin
        if (det_reset) r_hist <= 4'b0;
        else           r_hist <= {r_hist[2:0], sequence_out};
    end
    assign detector_in = (r_hist == 4'b1011);

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Cycle k = k-th cycle after the edge that samples start.
    task automatic build_model(input int n, input int lim, input int abort_at);
        int hs [MAXW];
        int hit_t [$];
        int h;
        int hist;
        int b;
        int normal_done;
        for (int k = 0; k < MAXT; k++) begin
            exp_dr[k] = 1'b1;
            exp_sq[k] = 1'b0;
        end
        exp_und      = 1'b0;
        exp_hits     = 0;
        exp_consumed = 0;
        if (n == 0) begin
            exp_done_t = 0;
            return;
        end
        h    = DET_RST_CYC + 1;
        hist = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                if (gaps[i] >= WORD_W) hist = 0;
                h += (gaps[i] + 1 > WORD_W) ? gaps[i] + 1 : WORD_W;
            end
            hs[i] = h;
            for (int j = 0; j < WORD_W; j++) begin
`ifdef SEQ_CTRL_LSB_FIRST_EN
                b = int'(words[i][j]);
`else
                b = int'(words[i][WORD_W-1-j]);
`endif
                hist = ((hist << 1) | b) & 15;
                if (hist == 11) hit_t.push_back(h + j);
            end
        end
        normal_done = hs[n-1] + WORD_W + DRAIN_CYC;
        exp_done_t  = normal_done;
        if (lim > 0 && hit_t.size() >= lim && hit_t[lim-1] + 3 < exp_done_t)
            exp_done_t = hit_t[lim-1] + 3;
        if (abort_at >= 0 && abort_at + 1 < exp_done_t)
            exp_done_t = abort_at + 1;
        foreach (hit_t[k]) if (hit_t[k] + 1 < exp_done_t) exp_hits++;
        for (int i = 0; i < n; i++) begin
            if (hs[i] < exp_done_t) exp_consumed++;
            if (i > 0 && gaps[i] >= WORD_W && hs[i-1] + WORD_W < exp_done_t) exp_und = 1'b1;
            for (int j = 0; j < WORD_W; j++) begin
                if (hs[i] + j < exp_done_t) begin
                    exp_dr[hs[i]+j] = 1'b0;
`ifdef SEQ_CTRL_LSB_FIRST_EN
                    exp_sq[hs[i]+j] = words[i][j];
`else
                    exp_sq[hs[i]+j] = words[i][WORD_W-1-j];
`endif
                end
            end
        end
        for (int d = 0; d < DRAIN_CYC; d++)
            if (normal_done - DRAIN_CYC + d < exp_done_t) exp_dr[normal_done-DRAIN_CYC+d] = 1'b0;
    endtask

    task automatic run_session(input string nm, input int n, input int lim,
                               input int abort_at, input int start_at);
        int   cyc;
        int   idx;
        int   gapcnt;
        int   consumed;
        int   k;
        logic hs_now;
        logic got_done;
        build_model(n, lim, abort_at);
        @(posedge clock); #1;
        start      = 1'b1;
        abort      = 1'b0;
        word_count = CNT_W'(n);
        hit_limit  = CNT_W'(lim);
        in_valid   = (n > 0);
        in_data    = (n > 0) ? words[0] : '0;
        idx = 0; gapcnt = 0; consumed = 0; got_done = 1'b0; cyc = 0;
        while (!got_done && cyc < exp_done_t + 40) begin
            @(negedge clock);
            k = cyc - 1;
            if (k >= 0 && k <= exp_done_t)
                check_val({nm, ":det_reset"}, det_reset, exp_dr[k]);
            if (k >= 0 && k < exp_done_t)
                check_val({nm, ":seq_out"}, sequence_out, exp_sq[k]);
            hs_now = in_valid && in_ready;
            if (done) begin
                got_done = 1'b1;
                check_val({nm, ":done_cycle"}, cyc, exp_done_t + 1);
                check_val({nm, ":hit_count"}, hit_count, exp_hits);
                check_val({nm, ":underrun"}, underrun, exp_und);
                check_val({nm, ":consumed"}, consumed, exp_consumed);
                check_val({nm, ":busy_in_done"}, busy, 1'b0);
            end
            @(posedge clock); #1;
            cyc++;
            start = ((cyc - 1) == start_at);
            abort = ((cyc - 1) == abort_at);
            if (hs_now) begin
                consumed++;
                idx++;
                if (idx < n) begin
                    gapcnt   = gaps[idx];
                    in_data  = words[idx];
                    in_valid = (gapcnt == 0);
                end else begin
                    in_valid = 1'b0;
                end
            end else if (!in_valid && idx > 0 && idx < n && gapcnt > 0) begin
                gapcnt--;
                in_valid = (gapcnt == 0);
            end
        end
        if (!got_done) check_val({nm, ":done_timeout"}, 32'd0, 32'd1);
        @(posedge clock); #1;
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        check_val({nm, ":done_single"}, done, 1'b0);
        check_val({nm, ":busy_after"}, busy, 1'b0);
    endtask

    task automatic reset_mid_shift();
        @(posedge clock); #1;
        start = 1'b1; word_count = 16'd2; hit_limit = '0; in_valid = 1'b1; in_data = 8'hBB;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        check_val("rst_pre_hits", hit_count, 1);
        check_val("rst_pre_busy", busy, 1'b1);
        #1 reset = 1'b1;
        #1;
        check_val("rst_det_reset", det_reset, 1'b1);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_hit_count", hit_count, 0);
        check_val("rst_seq_out", sequence_out, 1'b0);
        check_val("rst_in_ready", in_ready, 1'b0);
        check_val("rst_done", done, 1'b0);
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_val("reset_det_reset", det_reset, 1'b1);
        check_val("reset_in_ready", in_ready, 1'b0);
        check_val("reset_seq_out", sequence_out, 1'b0);
        check_val("reset_busy", busy, 1'b0);
        check_val("reset_done", done, 1'b0);
        check_val("reset_underrun", underrun, 1'b0);
        check_val("reset_hit_count", hit_count, 0);
        @(negedge clock);
        reset = 1'b0;

        // Single word 10111011.
        words[0] = 8'hBB; gaps[0] = 0;
        run_session("t1", 1, 0, -1, -1);
`ifndef SEQ_CTRL_LSB_FIRST_EN
        check_val("t1_hits_const", hit_count, 2);
`endif
        // Two contiguous words.
        words[0] = 8'h0B; words[1] = 8'h00; gaps[1] = 0;
        run_session("t2", 2, 0, -1, -1);
`ifndef SEQ_CTRL_LSB_FIRST_EN
        check_val("t2_hits_const", hit_count, 1);
`endif
        // Hit limit of one over three words.
        words[0] = 8'hBB; words[1] = 8'hBB; words[2] = 8'hBB; gaps[1] = 0; gaps[2] = 0;
        run_session("t3", 3, 1, -1, -1);
        // Source gap of three LOAD cycles; the spanning pattern is lost.
        words[0] = 8'h05; words[1] = 8'hB0; gaps[1] = WORD_W + 2;
        run_session("t4", 2, 0, -1, -1);
        // Zero words, start while busy, abort, abort together with limit.
        run_session("t5_zero", 0, 0, -1, -1);
        words[0] = 8'h5A; words[1] = 8'hBB; gaps[1] = 0;
        run_session("t5_restart", 2, 0, -1, 5);
        run_session("abort", 2, 0, 6, -1);
        words[0] = 8'hBB;
        run_session("abort_lim", 1, 1, 8, -1);
        words[0] = 8'hDD;
        run_session("dd", 1, 0, -1, -1);
`ifdef SEQ_CTRL_LSB_FIRST_EN
        check_val("dd_lsb_hits_const", hit_count, 2);
`endif
        reset_mid_shift();
        words[0] = 8'hBB;
        run_session("post_rst", 1, 0, -1, -1);

        for (int s = 0; s < 40; s++) begin
            int n;
            int lim;
            int ab;
            int st;
            n = $urandom_range(1, 5);
            gaps[0] = 0;
            for (int i = 0; i < n; i++) begin
                words[i] = ($urandom_range(0, 3) == 0) ? 8'hBB : WORD_W'($urandom);
                if (i > 0) gaps[i] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, WORD_W + 3);
            end
            lim = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 50) : -1;
            st  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 25) : -1;
            run_session($sformatf("rnd%0d", s), n, lim, ab, st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
